// File: rtl/vrf_read_port_scheduler_pkg.sv
// Shared types and default sizing for the VRF read-port scheduler.
package vrf_read_port_scheduler_pkg;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_READ_LATENCY = 2;
   localparam int DEF_CREDITS      = 4;

   typedef struct packed {
      logic [4:0] vs;
      logic [2:0] offset;
      logic [1:0] readSource;
      logic [2:0] instructionIndex;
   } vrf_rd_req_t;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vrf_read_credit_counter.sv
// Per-requester response-slot credit counter with sticky overflow flag.
module vrf_read_credit_counter
   import vrf_read_port_scheduler_pkg::*;
#(
   parameter int CREDITS = DEF_CREDITS
) (
   input  logic clock,
   input  logic reset,
   input  logic dec_i,
   input  logic inc_i,
   output logic nonzero_o,
   output logic err_o
);

   localparam int CW = $clog2(CREDITS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // Simultaneous take and return cancel; a return into a full counter is dropped and flagged.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (inc_i && !dec_i) begin
         if (cnt_q == CW'(CREDITS)) err_d = 1'b1;
         else                       cnt_d = cnt_q + CW'(1);
      end else if (dec_i && !inc_i) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= CW'(CREDITS);
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign nonzero_o = (cnt_q != '0);
   assign err_o     = err_q;

endmodule

// File: rtl/vrf_read_port_scheduler.sv
// Round-robin arbiter sharing one VRF read port among credit-limited requesters,
// with a fixed-latency tag pipe that routes read data back to the winner.
module vrf_read_port_scheduler
   import vrf_read_port_scheduler_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter int CREDITS      = DEF_CREDITS
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*5-1:0]   req_bits_vs,
   input  logic [NUM_REQ*3-1:0]   req_bits_offset,
   input  logic [NUM_REQ*2-1:0]   req_bits_readSource,
   input  logic [NUM_REQ*3-1:0]   req_bits_instructionIndex,
   output logic                   vrfReadRequest_valid,
   input  logic                   vrfReadRequest_ready,
   output logic [4:0]             vrfReadRequest_bits_vs,
   output logic [2:0]             vrfReadRequest_bits_offset,
   output logic [1:0]             vrfReadRequest_bits_readSource,
   output logic [2:0]             vrfReadRequest_bits_instructionIndex,
   input  logic [31:0]            vrfReadResult,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [31:0]            resp_data,
   input  logic [NUM_REQ-1:0]     credit_return,
   output logic                   credit_error
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   vrf_rd_req_t        req_fields [NUM_REQ];
   vrf_rd_req_t        win_fields;
   logic [NUM_REQ-1:0] has_credit, elig, cnt_err, win_oh;
   logic [IW-1:0]      rr_q, rr_d, win_idx;
   logic               block_q, gate, fire;
   logic               pipe_vld_q [READ_LATENCY];
   logic [NUM_REQ-1:0] pipe_tag_q [READ_LATENCY];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req_fields[i].vs               = req_bits_vs[i*5 +: 5];
      assign req_fields[i].offset           = req_bits_offset[i*3 +: 3];
      assign req_fields[i].readSource       = req_bits_readSource[i*2 +: 2];
      assign req_fields[i].instructionIndex = req_bits_instructionIndex[i*3 +: 3];
      assign win_oh[i] = (win_idx == IW'(i));

      vrf_read_credit_counter #(.CREDITS(CREDITS)) u_credit (
         .clock     (clock),
         .reset     (reset),
         .dec_i     (req_ready[i]),
         .inc_i     (credit_return[i]),
         .nonzero_o (has_credit[i]),
         .err_o     (cnt_err[i])
      );
   end

   assign elig = req_valid & has_credit;

   always_comb begin : arb
      int   idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      win_idx = rr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!found && elig[IW'(idx)]) begin
            found   = 1'b1;
            win_idx = IW'(idx);
         end
      end
   end

   // Requests are held off during reset and the cycle after it so the port starts quiet.
   assign gate                 = ~reset & ~block_q;
   assign vrfReadRequest_valid = (|elig) & gate;
   assign fire                 = vrfReadRequest_valid & vrfReadRequest_ready;
   assign req_ready            = win_oh & {NUM_REQ{fire}};

   assign win_fields                           = req_fields[win_idx];
   assign vrfReadRequest_bits_vs               = win_fields.vs;
   assign vrfReadRequest_bits_offset           = win_fields.offset;
   assign vrfReadRequest_bits_readSource       = win_fields.readSource;
   assign vrfReadRequest_bits_instructionIndex = win_fields.instructionIndex;

   assign rr_d = fire ? IW'(next_idx(int'(win_idx), NUM_REQ)) : rr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q    <= '0;
         block_q <= 1'b1;
         for (int s = 0; s < READ_LATENCY; s++) pipe_vld_q[s] <= 1'b0;
      end else begin
         rr_q          <= rr_d;
         block_q       <= 1'b0;
         pipe_vld_q[0] <= fire;
         for (int s = 1; s < READ_LATENCY; s++) pipe_vld_q[s] <= pipe_vld_q[s-1];
      end
   end

   always_ff @(posedge clock) begin
      pipe_tag_q[0] <= win_oh;
      for (int s = 1; s < READ_LATENCY; s++) pipe_tag_q[s] <= pipe_tag_q[s-1];
   end

   assign resp_valid   = (pipe_vld_q[READ_LATENCY-1] && gate) ? pipe_tag_q[READ_LATENCY-1] : '0;
   assign resp_data    = vrfReadResult;
   assign credit_error = |cnt_err;

endmodule

// File: tb/tb_vrf_read_port_scheduler.sv
// Directed bench for vrf_read_port_scheduler with default parameters (4 req, latency 2, 4 credits).
module tb_vrf_read_port_scheduler;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid, req_ready, resp_valid, credit_return;
   logic [N*5-1:0] req_bits_vs;
   logic [N*3-1:0] req_bits_offset, req_bits_instructionIndex;
   logic [N*2-1:0] req_bits_readSource;
   logic          vrfReadRequest_valid, vrfReadRequest_ready;
   logic [4:0]    vrfReadRequest_bits_vs;
   logic [2:0]    vrfReadRequest_bits_offset, vrfReadRequest_bits_instructionIndex;
   logic [1:0]    vrfReadRequest_bits_readSource;
   logic [31:0]   vrfReadResult, resp_data;
   logic          credit_error;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   vrf_read_port_scheduler dut (
      .clock                                (clock),
      .reset                                (reset),
      .req_valid                            (req_valid),
      .req_ready                            (req_ready),
      .req_bits_vs                          (req_bits_vs),
      .req_bits_offset                      (req_bits_offset),
      .req_bits_readSource                  (req_bits_readSource),
      .req_bits_instructionIndex            (req_bits_instructionIndex),
      .vrfReadRequest_valid                 (vrfReadRequest_valid),
      .vrfReadRequest_ready                 (vrfReadRequest_ready),
      .vrfReadRequest_bits_vs               (vrfReadRequest_bits_vs),
      .vrfReadRequest_bits_offset           (vrfReadRequest_bits_offset),
      .vrfReadRequest_bits_readSource       (vrfReadRequest_bits_readSource),
      .vrfReadRequest_bits_instructionIndex (vrfReadRequest_bits_instructionIndex),
      .vrfReadResult                        (vrfReadResult),
      .resp_valid                           (resp_valid),
      .resp_data                            (resp_data),
      .credit_return                        (credit_return),
      .credit_error                         (credit_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      logic [3:0] exp_oh;
      logic [3:0] ret_oh;

      reset                = 1'b1;
      req_valid            = '0;
      vrfReadRequest_ready = 1'b0;
      vrfReadResult        = '0;
      credit_return        = '0;
      for (int i = 0; i < N; i++) begin
         req_bits_vs[i*5 +: 5]               = 5'(i * 3 + 1);
         req_bits_offset[i*3 +: 3]           = 3'(i + 2);
         req_bits_readSource[i*2 +: 2]       = 2'(i);
         req_bits_instructionIndex[i*3 +: 3] = 3'(7 - i);
      end
      tick;

      // Reset cycle and first cycle after: everything quiet even with demand present.
      req_valid            = 4'b1111;
      vrfReadRequest_ready = 1'b1;
      settle;
      chk("rst_valid", 32'(vrfReadRequest_valid), 32'(0));
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_resp", 32'(resp_valid), 32'(0));
      chk("rst_cerr", 32'(credit_error), 32'(0));
      tick;
      reset = 1'b0;
      settle;
      chk("post_rst_valid", 32'(vrfReadRequest_valid), 32'(0));
      chk("post_rst_ready", 32'(req_ready), 32'(0));
      chk("post_rst_resp", 32'(resp_valid), 32'(0));
      tick;

      // All four requesting: grants rotate 0,1,2,3,... and responses follow two cycles later.
      for (int k = 0; k < 10; k++) begin
         req_valid     = (k < 8) ? 4'b1111 : 4'b0000;
         ret_oh        = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
         exp_oh        = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
         credit_return = ret_oh;
         vrfReadResult = 32'hA000_0000 + 32'(k);
         settle;
         chk("rr_grant", 32'(req_ready), 32'(exp_oh));
         chk("rr_resp", 32'(resp_valid), 32'(ret_oh));
         if (k < 8) chk("rr_vs", 32'(vrfReadRequest_bits_vs), 32'((k % 4) * 3 + 1));
         if (k >= 2) chk("rr_data", resp_data, 32'hA000_0000 + 32'(k));
         tick;
      end
      credit_return = '0;

      // Port stalled with req 0 and 3 pending: request holds on req 0, pointer does not move.
      req_valid            = 4'b1001;
      vrfReadRequest_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle;
         chk("stall_valid", 32'(vrfReadRequest_valid), 32'(1));
         chk("stall_vs", 32'(vrfReadRequest_bits_vs), 32'(1));
         chk("stall_off", 32'(vrfReadRequest_bits_offset), 32'(2));
         chk("stall_src", 32'(vrfReadRequest_bits_readSource), 32'(0));
         chk("stall_idx", 32'(vrfReadRequest_bits_instructionIndex), 32'(7));
         chk("stall_ready", 32'(req_ready), 32'(0));
         chk("stall_resp", 32'(resp_valid), 32'(0));
         tick;
      end
      vrfReadRequest_ready = 1'b1;
      settle;
      chk("unstall_grant0", 32'(req_ready), 32'(4'b0001));
      tick;
      settle;
      chk("unstall_grant3", 32'(req_ready), 32'(4'b1000));
      tick;
      req_valid     = '0;
      vrfReadResult = 32'hDEAD_BEEF;
      credit_return = 4'b0001;
      settle;
      chk("lat_resp0", 32'(resp_valid), 32'(4'b0001));
      chk("lat_data", resp_data, 32'hDEAD_BEEF);
      tick;
      vrfReadResult = 32'h1234_5678;
      credit_return = 4'b1000;
      settle;
      chk("lat_resp3", 32'(resp_valid), 32'(4'b1000));
      chk("lat_data3", resp_data, 32'h1234_5678);
      tick;
      credit_return = '0;

      // Only req 2, no returns: exactly four fires, then it is masked.
      req_valid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         settle;
         chk("cred_ready", 32'(req_ready), 32'((k < 4) ? 4'b0100 : 4'b0000));
         chk("cred_valid", 32'(vrfReadRequest_valid), 32'((k < 4) ? 1 : 0));
         chk("cred_resp", 32'(resp_valid), 32'((k >= 2 && k < 6) ? 4'b0100 : 4'b0000));
         tick;
      end
      req_valid     = '0;
      credit_return = 4'b0100;
      for (int k = 0; k < 4; k++) tick;
      credit_return = '0;
      settle;
      chk("cred_refill_err", 32'(credit_error), 32'(0));

      // Req 1: fire with a same-cycle return leaves credit at 3; two more returns overflow.
      req_valid = 4'b0010;
      settle;
      chk("ovf_fire_a", 32'(req_ready), 32'(4'b0010));
      tick;
      credit_return = 4'b0010;
      settle;
      chk("ovf_fire_b", 32'(req_ready), 32'(4'b0010));
      tick;
      req_valid = '0;
      settle;
      chk("ovf_resp_a", 32'(resp_valid), 32'(4'b0010));
      chk("ovf_err_c", 32'(credit_error), 32'(0));
      tick;
      settle;
      chk("ovf_resp_b", 32'(resp_valid), 32'(4'b0010));
      chk("ovf_err_d", 32'(credit_error), 32'(0));
      tick;
      credit_return = '0;
      settle;
      chk("ovf_err_set", 32'(credit_error), 32'(1));
      tick;
      settle;
      chk("ovf_err_sticky", 32'(credit_error), 32'(1));
      tick;

      // Reset right after a fire: the read is dropped and credits come back full.
      req_valid = 4'b0001;
      settle;
      chk("drop_fire", 32'(req_ready), 32'(4'b0001));
      tick;
      reset     = 1'b1;
      req_valid = '0;
      settle;
      chk("drop_rst_resp", 32'(resp_valid), 32'(0));
      tick;
      reset = 1'b0;
      settle;
      chk("drop_resp", 32'(resp_valid), 32'(0));
      chk("drop_cerr", 32'(credit_error), 32'(0));
      tick;
      settle;
      chk("drop_resp_late", 32'(resp_valid), 32'(0));
      tick;
      req_valid = 4'b1001;
      settle;
      chk("drop_rr_reset", 32'(req_ready), 32'(4'b0001));
      tick;
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         settle;
         chk("drop_credits", 32'(req_ready), 32'((k < 3) ? 4'b0001 : 4'b0000));
         tick;
      end
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
